// File: rtl/w450_pkg.sv
// rtl/w450_pkg.sv - shared width, controller state type and core opcodes for w450
package w450_pkg;

    localparam int N = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [N-1:0] OP_NOP = 8'h00;
    localparam logic [N-1:0] OP_LDI = 8'h01;
    localparam logic [N-1:0] OP_LD  = 8'h02;
    localparam logic [N-1:0] OP_ST  = 8'h03;
    localparam logic [N-1:0] OP_ADD = 8'h04;
    localparam logic [N-1:0] OP_JMP = 8'h05;
    localparam logic [N-1:0] OP_JZ  = 8'h06;
    localparam logic [N-1:0] OP_HLT = 8'hFF;

endpackage

// File: rtl/w450_mem_if.sv
// rtl/w450_mem_if.sv - core read/write ports plus loader stream and status
interface w450_mem_if;
    import w450_pkg::*;

    logic [N-1:0] mem_rd_addr1;
    logic [N-1:0] mem_rd_data1;
    logic [N-1:0] mem_rd_addr2;
    logic [N-1:0] mem_rd_data2;
    logic [N-1:0] mem_wr_addr;
    logic [N-1:0] mem_wr_data;
    logic         mem_wr_en;
    logic         load_valid;
    logic [N-1:0] load_data;
    logic         load_last;
    logic         load_ready;
    logic         load_start;
    logic         cpu_reset;
    logic [N-1:0] load_count;
    logic         load_overflow;
    logic         wr_fault;

    modport master (
        output mem_rd_addr1, mem_rd_addr2, mem_wr_addr, mem_wr_data, mem_wr_en,
        output load_valid, load_data, load_last, load_start,
        input  mem_rd_data1, mem_rd_data2, load_ready, cpu_reset,
        input  load_count, load_overflow, wr_fault
    );

    modport slave (
        input  mem_rd_addr1, mem_rd_addr2, mem_wr_addr, mem_wr_data, mem_wr_en,
        input  load_valid, load_data, load_last, load_start,
        output mem_rd_data1, mem_rd_data2, load_ready, cpu_reset,
        output load_count, load_overflow, wr_fault
    );

endinterface

// File: rtl/w450_mem_array.sv
// rtl/w450_mem_array.sv - 2**N x N storage, two async read ports, one sync write port
module w450_mem_array
    import w450_pkg::*;
(
    input  logic         clk,
    input  logic         i_we,
    input  logic [N-1:0] i_waddr,
    input  logic [N-1:0] i_wdata,
    input  logic [N-1:0] i_raddr1,
    output logic [N-1:0] o_rdata1,
    input  logic [N-1:0] i_raddr2,
    output logic [N-1:0] o_rdata2
);

    // Contents deliberately survive controller reset.
    logic [N-1:0] r_mem [2**N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/w450_mem.sv
// rtl/w450_mem.sv - w450 unified memory with byte-stream program loader
// Optional write protection of the loaded image: W450_MEM_WPROT_EN
module w450_mem
    import w450_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    w450_mem_if.slave    bus
);

    localparam logic [N-1:0] PTR_MAX = '1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_ptr;
    logic [N-1:0] r_count;
    logic         r_ovf;

    logic         w_hs;
    logic         w_ptr_max;
    logic         w_drop;
    logic         w_load_ready;
    logic         w_cpu_reset;
    logic         w_we;
    logic [N-1:0] w_waddr;
    logic [N-1:0] w_wdata;

    assign w_ptr_max = (r_ptr == PTR_MAX);
    assign w_hs      = bus.load_valid && w_load_ready;

`ifdef W450_MEM_WPROT_EN
    logic r_wr_fault;

    assign w_drop = bus.mem_wr_en && (bus.mem_wr_addr < r_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_fault <= 1'b0;
        end else begin
            r_wr_fault <= (r_state == ST_RUN) && w_drop;
        end
    end

    assign bus.wr_fault = r_wr_fault;
`else
    assign w_drop       = 1'b0;
    assign bus.wr_fault = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_cpu_reset  = 1'b1;
        w_we         = 1'b0;
        w_waddr      = bus.mem_wr_addr;
        w_wdata      = bus.mem_wr_data;
        case (r_state)
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (bus.load_valid) begin
                    w_we    = 1'b1;
                    w_waddr = r_ptr;
                    w_wdata = bus.load_data;
                    if (bus.load_last || w_ptr_max) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_cpu_reset = 1'b0;
                w_we        = bus.mem_wr_en && !w_drop;
                if (bus.load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN && bus.load_start) begin
                r_ptr   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_hs) begin
                // Pointer pins at the top address; count saturates with it.
                if (!w_ptr_max) begin
                    r_ptr <= r_ptr + 1'b1;
                end
                if (r_count != PTR_MAX) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_ptr_max && !bus.load_last) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready    = w_load_ready;
    assign bus.cpu_reset     = w_cpu_reset;
    assign bus.load_count    = r_count;
    assign bus.load_overflow = r_ovf;

    w450_mem_array u_array (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (bus.mem_rd_addr1),
        .o_rdata1 (bus.mem_rd_data1),
        .i_raddr2 (bus.mem_rd_addr2),
        .o_rdata2 (bus.mem_rd_data2)
    );

endmodule

// File: tb/tb_w450_mem.sv
// tb/tb_w450_mem.sv - directed self-checking bench for w450_mem
module tb_w450_mem;

`ifdef W450_MEM_WPROT_EN
    localparam logic PROT = 1'b1;
`else
    localparam logic PROT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    w450_mem_if bus ();

    w450_mem dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.mem_rd_addr1 = a;
        bus.mem_rd_addr2 = a;
        #1;
        chk({tag, "_p1"}, bus.mem_rd_data1, exp);
        chk({tag, "_p2"}, bus.mem_rd_data2, exp);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic core_wr(input logic [7:0] a, input logic [7:0] d);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = a;
        bus.mem_wr_data = d;
        tick();
        bus.mem_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.mem_rd_addr1 = '0;
        bus.mem_rd_addr2 = '0;
        bus.mem_wr_addr  = '0;
        bus.mem_wr_data  = '0;
        bus.mem_wr_en    = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = '0;
        bus.load_last    = 1'b0;
        bus.load_start   = 1'b0;

        tick();
        tick();
        chk("rst_ready", {7'd0, bus.load_ready}, 8'd1);
        chk("rst_cpu_reset", {7'd0, bus.cpu_reset}, 8'd1);
        chk("rst_count", bus.load_count, 8'd0);
        chk("rst_ovf", {7'd0, bus.load_overflow}, 8'd0);
        chk("rst_fault", {7'd0, bus.wr_fault}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Three-byte program; DRAIN one cycle, then RUN.
        load_byte(8'hA1, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h05, 1'b1);
        chk("drain_ready", {7'd0, bus.load_ready}, 8'd0);
        chk("drain_cpu_reset", {7'd0, bus.cpu_reset}, 8'd1);
        chk("load3_count", bus.load_count, 8'd3);
        tick();
        chk("run_cpu_reset", {7'd0, bus.cpu_reset}, 8'd0);
        chk("run_ready", {7'd0, bus.load_ready}, 8'd0);
        chk_mem("load3_m0", 8'h00, 8'hA1);
        chk_mem("load3_m1", 8'h01, 8'h22);
        chk_mem("load3_m2", 8'h02, 8'h05);

        // Write into the image (protected only with the macro), then just past it.
        core_wr(8'h02, 8'h99);
        chk("prot_fault_hi", {7'd0, bus.wr_fault}, {7'd0, PROT});
        tick();
        chk("prot_fault_lo", {7'd0, bus.wr_fault}, 8'd0);
        chk_mem("prot_m2", 8'h02, PROT ? 8'h05 : 8'h99);
        core_wr(8'h03, 8'h44);
        chk("prot_fault_a3", {7'd0, bus.wr_fault}, 8'd0);
        chk_mem("prot_m3", 8'h03, 8'h44);

        // Same-cycle read of a written address shows old data until the edge.
        core_wr(8'h40, 8'h11);
        bus.mem_rd_addr1 = 8'h40;
        bus.mem_rd_addr2 = 8'h40;
        bus.mem_wr_en    = 1'b1;
        bus.mem_wr_addr  = 8'h40;
        bus.mem_wr_data  = 8'h7E;
        #1;
        chk("wr_old_p1", bus.mem_rd_data1, 8'h11);
        tick();
        bus.mem_wr_en = 1'b0;
        chk("wr_new_p2", bus.mem_rd_data2, 8'h7E);
        chk("wr_new_p1", bus.mem_rd_data1, 8'h7E);

        // Loader bytes in RUN are ignored.
        load_byte(8'hEE, 1'b1);
        chk_mem("run_ignore_m0", 8'h00, 8'hA1);
        chk("run_ignore_count", bus.load_count, 8'd3);

        // Reload from address 0.
        pulse_start();
        chk("start_cpu_reset", {7'd0, bus.cpu_reset}, 8'd1);
        chk("start_ready", {7'd0, bus.load_ready}, 8'd1);
        chk("start_count", bus.load_count, 8'd0);
        load_byte(8'h5A, 1'b1);
        tick();
        chk_mem("reload_m0", 8'h00, 8'h5A);
        chk_mem("reload_m1", 8'h01, 8'h22);
        chk("reload_count", bus.load_count, 8'd1);

        // Full-memory stream without load_last.
        pulse_start();
        for (int i = 0; i < 255; i++) begin
            load_byte(8'(i) ^ 8'h3C, 1'b0);
        end
        chk("ovf_255_ready", {7'd0, bus.load_ready}, 8'd1);
        chk("ovf_255_count", bus.load_count, 8'hFF);
        chk("ovf_255_flag", {7'd0, bus.load_overflow}, 8'd0);
        load_byte(8'hFF ^ 8'h3C, 1'b0);
        chk("ovf_ready", {7'd0, bus.load_ready}, 8'd0);
        chk("ovf_flag", {7'd0, bus.load_overflow}, 8'd1);
        chk("ovf_count", bus.load_count, 8'hFF);
        tick();
        chk("ovf_run", {7'd0, bus.cpu_reset}, 8'd0);
        chk_mem("ovf_m0", 8'h00, 8'h3C);
        chk_mem("ovf_m80", 8'h80, 8'hBC);
        chk_mem("ovf_mff", 8'hFF, 8'hC3);

        // Reset mid-load abandons the load but keeps the array.
        pulse_start();
        chk("start_ovf_clr", {7'd0, bus.load_overflow}, 8'd0);
        load_byte(8'hB0, 1'b0);
        load_byte(8'hB1, 1'b0);
        chk("mid_count", bus.load_count, 8'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", bus.load_count, 8'd0);
        chk("mid_rst_cpu_reset", {7'd0, bus.cpu_reset}, 8'd1);
        tick();
        rst_n = 1'b1;
        load_byte(8'h33, 1'b1);
        tick();
        chk_mem("mid_m0", 8'h00, 8'h33);
        chk_mem("mid_m1", 8'h01, 8'hB1);
        chk("mid_reload_count", bus.load_count, 8'd1);
        chk("mid_reload_ovf", {7'd0, bus.load_overflow}, 8'd0);
        chk("mid_reload_run", {7'd0, bus.cpu_reset}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/w450_mem.md
# w450_mem

Unified program/data memory for the w450 processor, responding to the processor's two read ports and one write port. Provides a byte-stream program loader that holds the processor in reset while code is written from address 0, then releases it. Sits between the load source (testbench or host link) and the w450 core.

## Interface
- N, 8, data and address width; depth is 2**N bytes.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; resets the controller only, not the array.
- mem_rd_addr1  input  N  instruction read address from the core (its PC).
- mem_rd_data1  output  N  byte at mem_rd_addr1.
- mem_rd_addr2  input  N  data read address from the core (its r0).
- mem_rd_data2  output  N  byte at mem_rd_addr2.
- mem_wr_addr  input  N  core write address.
- mem_wr_data  input  N  core write data.
- mem_wr_en  input  1  core write strobe, sampled at the rising edge.
- load_valid  input  1  loader byte present.
- load_data  input  N  loader byte.
- load_last  input  1  marks the final loader byte; qualified by load_valid.
- load_ready  output  1  loader may transfer; reset value 1.
- load_start  input  1  in RUN, single-cycle request to reload.
- cpu_reset  output  1  active-high reset to the core; reset value 1.
- load_count  output  N  bytes loaded in the current or last load; reset value 0.
- load_overflow  output  1  sticky: load ended by the address limit, not by load_last; reset value 0.
- wr_fault  output  1  one-cycle pulse on a dropped core write; reset value 0.

## Operation
- States: LOAD, DRAIN, RUN. Reset enters LOAD with pointer 0.
- LOAD: load_ready=1, cpu_reset=1.
  - A handshake (load_valid && load_ready) writes load_data to mem[pointer] and increments pointer and load_count.
  - Handshake with load_last -> DRAIN.
  - Handshake at pointer 2**N-1 without load_last -> DRAIN, with load_overflow set. The pointer never wraps. In this case load_count saturates at 2**N-1 and the full-memory load is flagged by load_overflow.
  - Core writes are ignored.
- DRAIN: load_ready=0, cpu_reset=1. Lasts exactly one cycle, then -> RUN.
- RUN: load_ready=0, cpu_reset=0.
  - mem_wr_en writes mem_wr_data to mem[mem_wr_addr].
  - load_valid is ignored.
  - load_start -> LOAD. That edge clears the pointer, load_count and load_overflow, and asserts cpu_reset.
- Read ports are combinational from the array in every state and are independent. Both ports may read the same address.
- A read of the address being written in the same cycle returns old data until the rising edge.
- Asserting reset mid-load abandons the load (pointer 0, state LOAD). Array contents are retained.

## Timing
- Write latency: a byte written at edge k is visible on both read ports after edge k.
- Last-byte handshake at edge k: state is DRAIN after edge k. After edge k+1 the state is RUN and cpu_reset=0.
- load_ready deasserts after the last-handshake edge, so no further byte is accepted.
- Throughput: one loader byte per cycle.
- wr_fault is registered: it is high for the one cycle after the edge that dropped the write.

## Configuration
- W450_MEM_WPROT_EN defined: in RUN, core writes with mem_wr_addr < load_count are dropped and pulse wr_fault. This protects the loaded program image.
- W450_MEM_WPROT_EN undefined: all RUN writes commit and wr_fault is tied 0. The port remains.

## Structure
- Shared package w450_pkg:
  - width constant N.
  - the state type (LOAD, DRAIN, RUN).
  - the opcode constants shared with the core.
- Sub-module w450_mem_array: 2**N x N storage, two asynchronous read ports and one synchronous write port. The top muxes the write port between the loader and the core.

## Test plan
- Load 3 bytes 8'hA1, 8'h22, 8'h05 with load_last on the third -> mem[0..2] hold them; load_count=3; cpu_reset=0 two edges after the last handshake.
- RUN: mem_wr_en at addr 8'h40 data 8'h7E -> mem_rd_data2 at 8'h40 reads 8'h7E after the edge. The same cycle read via port 1 shows the old value.
- Stream 256 bytes with load_last never asserted -> load ends at byte 256, load_overflow=1, load_count=8'hFF, state reaches RUN.
- Assert reset low after 2 load bytes, then reload 1 byte 8'h33 with last -> mem[0]=8'h33; mem[1] keeps the earlier byte; load_count=1.
- With W450_MEM_WPROT_EN defined and load_count=3: core writes addr 2 -> dropped, wr_fault pulses once; addr 3 -> committed. Without the macro, the addr 2 write commits.
- load_start in RUN -> cpu_reset=1 and load_ready=1 after the edge; the next load overwrites from address 0.
